// File: rtl/reg_file.sv
// 32x32 register file with two combinational read ports, a write-bypass path
// and a per-register pending scoreboard for destination reservations.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  output logic        rd_ready_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  output logic        rd_ready_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  output logic        issue_stall,
  output logic [5:0]  pending_count
);

  logic [31:0] r_regs [32];
  logic [31:0] r_pending;
  logic [5:0]  r_pendingCount;

  logic        w_wrValid;
  logic        w_issueValid;
  logic        w_countInc;
  logic        w_countDec;
  logic [31:0] w_pendingNext;

  assign w_wrValid = wr_en && (wr_addr != 5'd0);

  // A same-cycle write to the reserved register releases the conflict, so no stall.
  assign issue_stall = issue_en && (issue_addr != 5'd0) && r_pending[issue_addr] &&
                       !(w_wrValid && (wr_addr == issue_addr));

  assign w_issueValid = issue_en && (issue_addr != 5'd0) && !issue_stall;

  always_comb begin
    rd_data_a  = r_regs[rd_addr_a];
    rd_ready_a = !r_pending[rd_addr_a];
    if (rd_addr_a == 5'd0) begin
      rd_data_a  = 32'd0;
      rd_ready_a = 1'b1;
    end else if (w_wrValid && (wr_addr == rd_addr_a)) begin
      rd_data_a  = wr_data;
      rd_ready_a = 1'b1;
    end
  end

  always_comb begin
    rd_data_b  = r_regs[rd_addr_b];
    rd_ready_b = !r_pending[rd_addr_b];
    if (rd_addr_b == 5'd0) begin
      rd_data_b  = 32'd0;
      rd_ready_b = 1'b1;
    end else if (w_wrValid && (wr_addr == rd_addr_b)) begin
      rd_data_b  = wr_data;
      rd_ready_b = 1'b1;
    end
  end

  // Issue is applied after the write clear so a same-register pair leaves the bit set.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_wrValid) begin
      w_pendingNext[wr_addr] = 1'b0;
    end
    if (w_issueValid) begin
      w_pendingNext[issue_addr] = 1'b1;
    end
  end

  // An unstalled issue to an already-pending register only happens alongside a
  // write to it, so it nets to no change.
  assign w_countInc = w_issueValid && !r_pending[issue_addr];
  assign w_countDec = w_wrValid && r_pending[wr_addr] &&
                      !(w_issueValid && (issue_addr == wr_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
      r_pending      <= 32'd0;
      r_pendingCount <= 6'd0;
    end else begin
      if (w_wrValid) begin
        r_regs[wr_addr] <= wr_data;
      end
      r_pending      <= w_pendingNext;
      r_pendingCount <= r_pendingCount + {5'd0, w_countInc} - {5'd0, w_countDec};
    end
  end

  assign pending_count = r_pendingCount;

endmodule
